interconn_priority: RTL and testbench

// - N-port crossbar between MVU tiles: each sender pushes one (address, word) per cycle to any

---
 rtl/interconn_pkg.sv | 23 ++
 rtl/interconn_priority_arb.sv | 54 +++++
 rtl/interconn_priority.sv | 96 +++++++++
 tb/tb_interconn_priority.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/interconn_pkg.sv
// rtl/interconn_pkg.sv - shared sizes, port types and arbitration helper for the MVU crossbar
//
// Purpose : common definitions imported by interconn_priority and interconn_priority_arb.
//           N     number of MVUs (sender ports = receiver ports)
//           W     data word width
//           BADDR memory address width
// Ports   : none (package).
package interconn_pkg;

    localparam int N     = 8;
    localparam int W     = 64;
    localparam int BADDR = 15;

    typedef logic [N-1:0]     sid_t;
    typedef logic [BADDR-1:0] addr_t;
    typedef logic [W-1:0]     word_t;

    // Two's-complement trick: v & -v isolates the lowest set bit (0 stays 0).
    function automatic sid_t lowest_onehot(input sid_t v);
        return v & (~v + sid_t'(1));
    endfunction

endpackage

// File: rtl/interconn_priority_arb.sv
// rtl/interconn_priority_arb.sv - single-receiver arbiter, fixed priority or round-robin
//
// Purpose : picks one requester for one receiver port.
//           Macro INTERCONN_PRIORITY_RR_EN undefined: lowest requester index wins.
//           Macro INTERCONN_PRIORITY_RR_EN defined:   round-robin, pointer marks the
//           highest-priority index and moves past each grant; held on idle cycles.
// Ports   : clk  in  clock (round-robin build only)
//           clr  in  synchronous active-high reset of the pointer (round-robin build only)
//           req  in  [N-1:0] request vector, bit i = sender i
//           gnt  out [N-1:0] one-hot grant, 0 when no request
module interconn_priority_arb
    import interconn_pkg::*;
(
`ifdef INTERCONN_PRIORITY_RR_EN
    input  logic clk,
    input  logic clr,
`endif
    input  sid_t req,
    output sid_t gnt
);

`ifdef INTERCONN_PRIORITY_RR_EN
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q, ptr_d;
    sid_t          hi_req;

    always_comb begin
        // Requests at or above the pointer go first; fall back to a plain
        // lowest-index pick, which covers the wrap-around part of the search.
        hi_req = req & (sid_t'({N{1'b1}}) << ptr_q);
        gnt    = (hi_req != '0) ? lowest_onehot(hi_req) : lowest_onehot(req);
        ptr_d  = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt = lowest_onehot(req);
    end
`endif

endmodule

// File: rtl/interconn_priority.sv
// rtl/interconn_priority.sv - N-port MVU crossbar with per-receiver arbitration, registered outputs
//
// Purpose : every sender may write one (address, word) to any subset of receivers per
//           cycle; each receiver takes at most one write per cycle, losers are dropped.
//           Arbitration mode selected by macro INTERCONN_PRIORITY_RR_EN (see arbiter).
//           Latency one cycle, full throughput.
// Ports   : clk        in  clock
//           clr        in  synchronous active-high reset
//           send_to    in  [N-1:0] x N      destination bitmask per sender
//           send_en    in  1 x N            request valid per sender
//           send_addr  in  [BADDR-1:0] x N  destination address per sender
//           send_word  in  [W-1:0] x N      data word per sender
//           recv_from  out [N-1:0] x N      one-hot granted sender per receiver, 0 when idle
//           recv_en    out 1 x N            write strobe per receiver
//           recv_addr  out [BADDR-1:0] x N  write address per receiver, 0 when idle
//           recv_word  out [W-1:0] x N      write data per receiver, 0 when idle
module interconn_priority
    import interconn_pkg::*;
(
    input  logic  clk,
    input  logic  clr,
    input  sid_t  send_to   [N-1:0],
    input  logic  send_en   [N-1:0],
    input  addr_t send_addr [N-1:0],
    input  word_t send_word [N-1:0],
    output sid_t  recv_from [N-1:0],
    output logic  recv_en   [N-1:0],
    output addr_t recv_addr [N-1:0],
    output word_t recv_word [N-1:0]
);

    sid_t  req [N-1:0];
    sid_t  gnt [N-1:0];

    sid_t  recv_from_q [N-1:0], recv_from_d [N-1:0];
    logic  recv_en_q   [N-1:0], recv_en_d   [N-1:0];
    addr_t recv_addr_q [N-1:0], recv_addr_d [N-1:0];
    word_t recv_word_q [N-1:0], recv_word_d [N-1:0];

    // Transpose: req[j][i] is sender i asking for receiver j.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            req[j] = '0;
            for (int i = 0; i < N; i++) begin
                req[j][i] = send_en[i] & send_to[i][j];
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_arb
        interconn_priority_arb u_arb (
`ifdef INTERCONN_PRIORITY_RR_EN
            .clk (clk),
            .clr (clr),
`endif
            .req (req[j]),
            .gnt (gnt[j])
        );
    end

    // AND-OR mux on the one-hot grant; an empty grant yields all-zero outputs.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            recv_from_d[j] = gnt[j];
            recv_en_d[j]   = |gnt[j];
            recv_addr_d[j] = '0;
            recv_word_d[j] = '0;
            for (int i = 0; i < N; i++) begin
                recv_addr_d[j] = recv_addr_d[j] | (send_addr[i] & {BADDR{gnt[j][i]}});
                recv_word_d[j] = recv_word_d[j] | (send_word[i] & {W{gnt[j][i]}});
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (clr) begin
                recv_from_q[j] <= '0;
                recv_en_q[j]   <= 1'b0;
                recv_addr_q[j] <= '0;
                recv_word_q[j] <= '0;
            end else begin
                recv_from_q[j] <= recv_from_d[j];
                recv_en_q[j]   <= recv_en_d[j];
                recv_addr_q[j] <= recv_addr_d[j];
                recv_word_q[j] <= recv_word_d[j];
            end
        end
    end

    assign recv_from = recv_from_q;
    assign recv_en   = recv_en_q;
    assign recv_addr = recv_addr_q;
    assign recv_word = recv_word_q;

endmodule

// File: tb/tb_interconn_priority.sv
// tb/tb_interconn_priority.sv - scoreboard bench for interconn_priority (both arbitration builds)
module tb_interconn_priority;
    import interconn_pkg::*;

    typedef struct packed {
        logic  en;
        sid_t  from;
        addr_t addr;
        word_t word;
    } rx_t;

    typedef rx_t [N-1:0] row_t;

    logic  clk;
    logic  clr;
    sid_t  send_to   [N-1:0];
    logic  send_en   [N-1:0];
    addr_t send_addr [N-1:0];
    word_t send_word [N-1:0];
    sid_t  recv_from [N-1:0];
    logic  recv_en   [N-1:0];
    addr_t recv_addr [N-1:0];
    word_t recv_word [N-1:0];

    interconn_priority dut (
        .clk       (clk),
        .clr       (clr),
        .send_to   (send_to),
        .send_en   (send_en),
        .send_addr (send_addr),
        .send_word (send_word),
        .recv_from (recv_from),
        .recv_en   (recv_en),
        .recv_addr (recv_addr),
        .recv_word (recv_word)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Staging copy of one input vector plus its hand-derived expected row.
    logic  st_clr;
    sid_t  st_to   [N-1:0];
    logic  st_en   [N-1:0];
    addr_t st_addr [N-1:0];
    word_t st_word [N-1:0];
    row_t  st_exp;

    row_t  sb_q  [$];
    string tag_q [$];

    int checks = 0;
    int errors = 0;

    task automatic stage_idle();
        st_clr = 1'b0;
        st_exp = '0;
        for (int i = 0; i < N; i++) begin
            st_to[i]   = '0;
            st_en[i]   = 1'b0;
            st_addr[i] = '0;
            st_word[i] = '0;
        end
    endtask

    task automatic stage_req(input int i, input sid_t to, input addr_t a, input word_t w);
        st_en[i]   = 1'b1;
        st_to[i]   = to;
        st_addr[i] = a;
        st_word[i] = w;
    endtask

    task automatic expect_rx(input int j, input sid_t from, input addr_t a, input word_t w);
        st_exp[j] = '{en: 1'b1, from: from, addr: a, word: w};
    endtask

    // Apply the staged vector at the falling edge so the next rising edge samples it.
    task automatic issue(input string tag);
        @(negedge clk);
        clr = st_clr;
        for (int i = 0; i < N; i++) begin
            send_to[i]   = st_to[i];
            send_en[i]   = st_en[i];
            send_addr[i] = st_addr[i];
            send_word[i] = st_word[i];
        end
        sb_q.push_back(st_exp);
        tag_q.push_back(tag);
    endtask

    // Monitor: one expected row per sampled edge, checked 1 time unit after it.
    always @(posedge clk) begin
        row_t  exp_row;
        string tag;
        rx_t   got;
        #1;
        if (sb_q.size() > 0) begin
            exp_row = sb_q.pop_front();
            tag     = tag_q.pop_front();
            for (int j = 0; j < N; j++) begin
                got = '{en: recv_en[j], from: recv_from[j], addr: recv_addr[j], word: recv_word[j]};
                checks++;
                if (got !== exp_row[j]) begin
                    errors++;
                    $display("FAIL %s rx%0d: got en=%0b from=%h addr=%h word=%h, expected en=%0b from=%h addr=%h word=%h",
                             tag, j, got.en, got.from, got.addr, got.word,
                             exp_row[j].en, exp_row[j].from, exp_row[j].addr, exp_row[j].word);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        word_t wv;
        int    drain;

        clr = 1'b1;
        for (int i = 0; i < N; i++) begin
            send_to[i]   = '0;
            send_en[i]   = 1'b0;
            send_addr[i] = '0;
            send_word[i] = '0;
        end

        // Reset with a live request pending: outputs must stay zero.
        stage_idle();
        st_clr = 1'b1;
        stage_req(3, 8'hFF, 15'h0123, 64'h1111_2222_3333_4444);
        issue("reset0");
        issue("reset1");

        // Every 1-to-1 pair, back to back.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                stage_idle();
                wv = (i % 2 == 1) ? 64'hdeadbeefdeadbeef : 64'hbeefdeadbeefdead;
                stage_req(i, sid_t'(1 << j), addr_t'(i + j + 1), wv);
                expect_rx(j, sid_t'(1 << i), addr_t'(i + j + 1), wv);
                issue($sformatf("pair_s%0d_r%0d", i, j));
            end
        end

        // Reset arbiter state, then collide senders 2 and 5 on receiver 3 twice.
        stage_idle();
        st_clr = 1'b1;
        issue("clr_before_collision");

        stage_idle();
        stage_req(2, 8'h08, 15'h0022, 64'h2222_2222_2222_2222);
        stage_req(5, 8'h08, 15'h0055, 64'h5555_5555_5555_5555);
        expect_rx(3, 8'h04, 15'h0022, 64'h2222_2222_2222_2222);
        issue("collision_1");
`ifdef INTERCONN_PRIORITY_RR_EN
        expect_rx(3, 8'h20, 15'h0055, 64'h5555_5555_5555_5555);
`endif
        issue("collision_2");

        // Multicast from sender 1 to all receivers.
        stage_idle();
        stage_req(1, 8'hFF, 15'h0007, 64'h1234);
        for (int j = 0; j < N; j++) expect_rx(j, 8'h02, 15'h0007, 64'h1234);
        issue("multicast");

        // send_en low with nonzero payload: nothing delivered.
        stage_idle();
        for (int i = 0; i < N; i++) begin
            st_to[i]   = 8'hA5;
            st_addr[i] = addr_t'(i + 100);
            st_word[i] = 64'hFFFF_0000_FFFF_0000;
        end
        issue("idle_en0");

        // send_en high with empty destination mask: nothing delivered.
        stage_idle();
        stage_req(6, 8'h00, 15'h7FFF, 64'hCAFE);
        issue("empty_mask");

        // Reset mid-traffic, then the same request delivers normally.
        stage_idle();
        stage_req(0, 8'h10, 15'h0044, 64'h0BAD_F00D_0BAD_F00D);
        issue("pre_reset_traffic");
        sb_q[sb_q.size() - 1][4] = '{en: 1'b1, from: 8'h01, addr: 15'h0044, word: 64'h0BAD_F00D_0BAD_F00D};
        st_clr = 1'b1;
        issue("reset_mid");
        st_clr = 1'b0;
        expect_rx(4, 8'h01, 15'h0044, 64'h0BAD_F00D_0BAD_F00D);
        issue("post_reset");

        stage_idle();
        issue("final_idle");

        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected rows still queued, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
